int_sqrt: RTL and testbench

Multi-cycle integer square-root unit: on a request it captures a WIDTH-bit unsigned operand and returns floor(sqrt(in)) using a restoring digit-by-digit algorithm. It produces one root bit per clock. Completion is signalled on a four-phase req/fin handshake. It sits as a shared arithmetic slave behind any controller that needs integer roots, and runs at design clock rate with no multiplier.

---
 rtl/int_sqrt_pkg.sv | 15 +
 rtl/int_sqrt_if.sv | 12 +
 rtl/int_sqrt_step.sv | 26 ++
 rtl/int_sqrt.sv | 90 +++++++++
 tb/tb_int_sqrt.sv | 128 ++++++++++++
 5 files changed

// File: rtl/int_sqrt_pkg.sv
// int_sqrt_pkg: shared FSM encoding and sizing helper for the integer square-root unit
package int_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Iteration counter width; a single iteration still needs one bit.
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_sqrt_if.sv
// int_sqrt_if: four-phase req/fin handshake plus operand and result buses
interface int_sqrt_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             fin;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (output req, in, input fin, out);
    modport slave  (input req, in, output fin, out);
endinterface

// File: rtl/int_sqrt_step.sv
// int_sqrt_step: one restoring root-digit iteration consuming one operand bit-pair
module int_sqrt_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH/2+1:0] r,
    input  logic [WIDTH/2-1:0] q,
    input  logic [1:0]         pair,
    output logic [WIDTH/2+1:0] r_next,
    output logic [WIDTH/2-1:0] q_next
);
    localparam int HALF = WIDTH / 2;
    localparam int RW   = HALF + 2;

    logic [RW-1:0] r_sh;
    logic [RW-1:0] t;
    logic          fit;

    // Shift in the next bit-pair, trial-subtract 4q+1 and keep it only if it fits.
    always_comb begin
        r_sh   = (r << 2) | RW'(pair);
        t      = {q, 2'b01};
        fit    = r_sh >= t;
        r_next = fit ? r_sh - t : r_sh;
        q_next = (q << 1) | HALF'(fit);
    end
endmodule

// File: rtl/int_sqrt.sv
// int_sqrt: multi-cycle floor(sqrt(in)), one root bit per clock, four-phase handshake
module int_sqrt
    import int_sqrt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    int_sqrt_if.slave bus
);
    localparam int              HALF = WIDTH / 2;
    localparam int              RW   = HALF + 2;
    localparam int              CW   = cnt_width(HALF);
    localparam logic [CW-1:0]   LAST = CW'(HALF - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [RW-1:0]    r_q, r_d, r_step;
    logic [HALF-1:0]  q_q, q_d, q_step;
    logic [HALF-1:0]  out_q, out_d;
    logic             fin_q, fin_d;

    int_sqrt_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .pair   (opnd_q[WIDTH-1 -: 2]),
        .r_next (r_step),
        .q_next (q_step)
    );

    // Next-state logic: capture in IDLE, iterate in CALC (abort on req low), wait for release in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        r_d     = r_q;
        q_d     = q_q;
        out_d   = out_q;
        // fin trails entry into DONE by one edge and drops on the edge that sees req low.
        fin_d   = (state_q == DONE) && bus.req;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = CALC;
                opnd_d  = bus.in;
                r_d     = '0;
                q_d     = '0;
                cnt_d   = '0;
            end
            CALC: if (!bus.req) begin
                state_d = IDLE;
            end else begin
                r_d    = r_step;
                q_d    = q_step;
                opnd_d = opnd_q << 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_d   = q_step;
                    state_d = DONE;
                end
            end
            DONE: if (!bus.req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            r_q     <= '0;
            q_q     <= '0;
            out_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            r_q     <= r_d;
            q_q     <= q_d;
            out_q   <= out_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.fin = fin_q;
    assign bus.out = WIDTH'(out_q);
endmodule

// File: tb/tb_int_sqrt.sv
// tb_int_sqrt: directed and random scoreboard checks of int_sqrt through its handshake
module tb_int_sqrt;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    int_sqrt_if #(.WIDTH(32)) bus ();

    int_sqrt #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt(input logic [31:0] a);
        longint unsigned lo = 0, hi = 65536, m;
        while (hi - lo > 1) begin
            m = (lo + hi) / 2;
            if (m * m <= longint'(a)) lo = m;
            else hi = m;
        end
        return lo[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full handshake from IDLE; optionally changes the operand mid-calculation.
    task automatic do_op(input logic [31:0] a, input string tag, input bit poke = 1'b0);
        int n;
        logic [31:0] e;
        bus.in  = a;
        bus.req = 1'b1;
        exp_q.push_back(isqrt(a));
        @(posedge clk); #1;
        n = 0;
        while (!bus.fin && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 3) bus.in = 32'd99;
        end
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, " latency"}, 64'(n), 64'd17);
        check({tag, " out"}, 64'(bus.out), 64'(e));
        bus.req = 1'b0;
        @(posedge clk); #1;
        check({tag, " fin release"}, 64'(bus.fin), 64'd0);
        check({tag, " out hold"}, 64'(bus.out), 64'(e));
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] o;
        bit seen;
        bus.req = 1'b0;
        bus.in  = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset fin", 64'(bus.fin), 64'd0);
        check("reset out", 64'(bus.out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(32'd10454520, "basic");
        check("basic value", 64'(last_exp), 64'd3233);
        do_op(32'd0, "zero");
        do_op(32'd1, "one");
        do_op(32'd15, "fifteen");
        do_op(32'd16, "sixteen");
        do_op(32'hFFFFFFFF, "max");
        do_op(32'hFFFE0001, "max square");
        do_op(32'd65536, "65536");
        do_op(32'd10000, "in change", 1'b1);
        check("in change value", 64'(bus.out), 64'd100);

        // Abort after five iterations.
        bus.in  = 32'd12345;
        bus.req = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        bus.req = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.fin) seen = 1'b1;
        end
        check("abort fin", 64'(seen), 64'd0);
        check("abort out", 64'(bus.out), 64'(last_exp));
        do_op(32'd12345, "after abort");

        // Asynchronous reset mid-calculation.
        bus.in  = 32'd777777;
        bus.req = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("async reset fin", 64'(bus.fin), 64'd0);
        check("async reset out", 64'(bus.out), 64'd0);
        bus.req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'd777777, "after reset");

        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            if (i % 4 == 1) a = a >> (i % 31);
            do_op(a, "random");
            o = 64'(bus.out);
            check("random bound", 64'((o * o <= 64'(a)) && ((o + 1) * (o + 1) > 64'(a))), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
